hpb_router: RTL

//  Parametrised host parameter bus router: decodes host config messages (core-clock domain,

---
 rtl/tts_pkg.sv | 41 ++++
 rtl/hpb_cmd_decode.sv | 42 ++++
 rtl/hpb_router.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/tts_pkg.sv
// Shared host-message layout and command/status types for the host parameter bus.
// The field offsets describe where each field sits inside in_config_data.
package tts_pkg;

    typedef enum logic [7:0] {
        HPB_WR = 8'h01,
        HPB_RD = 8'h02
    } t_hpb_cmd;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_BAD_TGT = 2'd1,
        ST_BAD_CMD = 2'd2,
        ST_TIMEOUT = 2'd3
    } t_hpb_status;

    localparam int unsigned CMD_B      = 0;
    localparam int unsigned CMD_W      = 8;
    localparam int unsigned RAM_B      = 8;
    localparam int unsigned RAM_W      = 8;
    localparam int unsigned ADDR_B     = 16;
    localparam int unsigned ADDR_MAX_W = 32;
    localparam int unsigned BYTE_EN_B  = 48;
    localparam int unsigned BE_MAX_W   = 16;
    localparam int unsigned DATA_B     = 64;
    localparam int unsigned DATA_MAX_W = 128;

    typedef struct packed {
        logic [DATA_MAX_W-1:0] data;
        logic [BE_MAX_W-1:0]   byte_en;
        logic [ADDR_MAX_W-1:0] addr;
        logic [RAM_W-1:0]      ram;
        logic [CMD_W-1:0]      cmd;
    } t_host_msg_map;

    // Width of a target index; a single target still needs one bit.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hpb_cmd_decode.sv
// Combinational strip of a host message into its fields, plus classification
// of unknown targets (checked first) and unknown commands.
module hpb_cmd_decode
    import tts_pkg::*;
#(
    parameter int unsigned NUM_TGT = 4,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned CFG_W   = 256,
    parameter int unsigned SEL_W   = 2
) (
    input  logic [CFG_W-1:0]    msg,
    output logic [SEL_W-1:0]    sel,
    output logic                is_wr,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   data,
    output logic [DATA_W/8-1:0] byte_en,
    output t_hpb_status         status
);
    logic [CMD_W-1:0] cmd;
    logic [RAM_W-1:0] ram;
    logic             unused_msg;

    always_comb begin
        cmd        = msg[CMD_B +: CMD_W];
        ram        = msg[RAM_B +: RAM_W];
        addr       = msg[ADDR_B +: ADDR_W];
        byte_en    = msg[BYTE_EN_B +: DATA_W/8];
        data       = msg[DATA_B +: DATA_W];
        sel        = ram[SEL_W-1:0];
        is_wr      = (cmd == HPB_WR);
        unused_msg = ^msg;
        if (ram >= RAM_W'(NUM_TGT)) begin
            status = ST_BAD_TGT;
        end else if (cmd != HPB_WR && cmd != HPB_RD) begin
            status = ST_BAD_CMD;
        end else begin
            status = ST_OK;
        end
    end

endmodule

// File: rtl/hpb_router.sv
// Host parameter bus router: one command in flight, routed to a single RCB target,
// with per-command status response, done timeout and saturating activity counters.
module hpb_router
    import tts_pkg::*;
#(
    parameter int unsigned NUM_TGT     = 4,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned CFG_W       = 256,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter logic [15:0] CNT_MAX     = 16'hFFFF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_config_valid,
    input  logic [CFG_W-1:0]          in_config_data,
    output logic                      in_config_accept,
    output logic [NUM_TGT-1:0]        tgt_wr_req,
    output logic [NUM_TGT-1:0]        tgt_rd_req,
    output logic [ADDR_W-1:0]         tgt_addr,
    output logic [DATA_W-1:0]         tgt_wr_data,
    output logic [DATA_W/8-1:0]       tgt_byte_en,
    input  logic [NUM_TGT-1:0]        tgt_done,
    input  logic [NUM_TGT*DATA_W-1:0] tgt_rd_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [1:0]                rsp_status,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [15:0]               cnt_wr,
    output logic [15:0]               cnt_rd,
    output logic [15:0]               cnt_err
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned SEL_W = sel_w(NUM_TGT);
    localparam int unsigned TMO_W = sel_w(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } t_state;

    t_state             state, state_nxt;
    t_hpb_status        dec_status, status_q;
    logic [SEL_W-1:0]   dec_sel, sel;
    logic               dec_wr, is_wr;
    logic [ADDR_W-1:0]  dec_addr;
    logic [DATA_W-1:0]  dec_data, rd_mux;
    logic [BE_W-1:0]    dec_be;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [NUM_TGT-1:0] sel_onehot;
    logic               capture, handshake, done_sel, tmo_hit;

    hpb_cmd_decode #(
        .NUM_TGT (NUM_TGT),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .CFG_W   (CFG_W),
        .SEL_W   (SEL_W)
    ) u_decode (
        .msg     (in_config_data),
        .sel     (dec_sel),
        .is_wr   (dec_wr),
        .addr    (dec_addr),
        .data    (dec_data),
        .byte_en (dec_be),
        .status  (dec_status)
    );

    always_comb begin
        in_config_accept = (state == S_IDLE);
        rsp_valid        = (state == S_RESP);
        rsp_status       = status_q;
        capture          = in_config_valid && (state == S_IDLE);
        handshake        = rsp_ready && (state == S_RESP);
        sel_onehot       = '0;
        rd_mux           = '0;
        for (int unsigned i = 0; i < NUM_TGT; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_onehot[i] = 1'b1;
                rd_mux        = tgt_rd_data[i*DATA_W +: DATA_W];
            end
        end
        // Only the addressed target's done counts; the others are masked off.
        done_sel   = |(tgt_done & sel_onehot);
        tmo_hit    = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
        tgt_wr_req = (state == S_ISSUE && is_wr)  ? sel_onehot : '0;
        tgt_rd_req = (state == S_ISSUE && !is_wr) ? sel_onehot : '0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (capture) state_nxt = (dec_status == ST_OK) ? S_ISSUE : S_RESP;
            S_ISSUE: if (done_sel || tmo_hit) state_nxt = S_RESP;
            S_RESP:  if (handshake) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel         <= '0;
            is_wr       <= 1'b0;
            tmo_cnt     <= '0;
            tgt_addr    <= '0;
            tgt_wr_data <= '0;
            tgt_byte_en <= '0;
            status_q    <= ST_OK;
            rsp_data    <= '0;
            cnt_wr      <= '0;
            cnt_rd      <= '0;
            cnt_err     <= '0;
        end else begin
            if (capture) begin
                sel      <= dec_sel;
                is_wr    <= dec_wr;
                tmo_cnt  <= '0;
                status_q <= dec_status;
                rsp_data <= '0;
                if (dec_status == ST_OK) begin
                    tgt_addr    <= dec_addr;
                    tgt_wr_data <= dec_data;
                    tgt_byte_en <= dec_be;
                end
            end
            // done is tested before the timeout so a late-but-present done still wins.
            if (state == S_ISSUE) begin
                if (done_sel) begin
                    status_q <= ST_OK;
                    rsp_data <= is_wr ? '0 : rd_mux;
                end else if (tmo_hit) begin
                    status_q <= ST_TIMEOUT;
                    rsp_data <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end
            if (handshake) begin
                if (status_q != ST_OK) begin
                    if (cnt_err != CNT_MAX) cnt_err <= cnt_err + 16'd1;
                end else if (is_wr) begin
                    if (cnt_wr != CNT_MAX) cnt_wr <= cnt_wr + 16'd1;
                end else begin
                    if (cnt_rd != CNT_MAX) cnt_rd <= cnt_rd + 16'd1;
                end
            end
        end
    end

endmodule
